// File: rtl/alu_seq_unit_if.sv
// ---------------------------------------------------------------------------
// alu_seq_unit_if
// Handshake and result bus between the operand-issue logic (master) and the
// sequenced ALU (slave).
//   In_Valid / In_Ready   : operation handshake (master -> slave)
//   A, B, ALU_FUN         : operands and 4-bit function code
//   Out_Valid / Out_Ready : result handshake (slave -> master)
//   Result, Result_Hi     : primary result and upper half / remainder
//   Carry_OUT, Zero_Flag,
//   Err_Flag, Unit_Sel    : flags registered alongside the result
//   Busy                  : divider iterating
// ---------------------------------------------------------------------------
interface alu_seq_unit_if #(
  parameter int WIDTH = 16
) ();
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_FUN;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Result_Hi;
  logic             Carry_OUT;
  logic             Zero_Flag;
  logic             Err_Flag;
  logic [1:0]       Unit_Sel;
  logic             Busy;

  modport master (
    output In_Valid, A, B, ALU_FUN, Out_Ready,
    input  In_Ready, Out_Valid, Result, Result_Hi, Carry_OUT, Zero_Flag,
           Err_Flag, Unit_Sel, Busy
  );

  modport slave (
    input  In_Valid, A, B, ALU_FUN, Out_Ready,
    output In_Ready, Out_Valid, Result, Result_Hi, Carry_OUT, Zero_Flag,
           Err_Flag, Unit_Sel, Busy
  );
endinterface

// File: rtl/alu_seq_unit.sv
// ---------------------------------------------------------------------------
// alu_seq_unit
// Handshaked four-unit ALU (arith / logic / compare / shift) with a
// single-entry registered output stage, full-width multiply and an iterative
// restoring unsigned divider.
// Ports:
//   CLK  : clock
//   RST  : synchronous active-high reset (aborts a running division)
//   bus  : alu_seq_unit_if.slave - operand handshake, result handshake, flags
// Parameters:
//   WIDTH      : operand/result width (>=4, power of two)
//   SIGNED_CMP : compare and arithmetic shift-right use two's complement
// ---------------------------------------------------------------------------
module alu_seq_unit #(
  parameter int WIDTH      = 16,
  parameter bit SIGNED_CMP = 1'b0
) (
  input logic           CLK,
  input logic           RST,
  alu_seq_unit_if.slave bus
);

  localparam int                SH_W     = $clog2(WIDTH);
  localparam int                CNT_W    = SH_W;
  localparam logic [SH_W:0]     W_LIT    = (SH_W+1)'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH-1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Output stage registers
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_carry;
  logic             r_zero;
  logic             r_err;
  logic [1:0]       r_unit_sel;
  logic             r_out_valid;

  // Divider working registers
  logic [WIDTH-1:0] r_div_q;    // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_div_rem;
  logic [WIDTH-1:0] r_div_b;
  logic [CNT_W-1:0] r_div_cnt;

  // Handshake decode
  logic       w_in_ready;
  logic       w_accept;
  logic       w_div_start;
  logic       w_div_last;
  logic [1:0] w_unit;
  logic [1:0] w_op;

  // Datapath wires
  logic [WIDTH:0]          w_sum;
  logic [WIDTH-1:0]        w_diff;
  logic [2*WIDTH-1:0]      w_prod;
  logic                    w_eq;
  logic                    w_lt_s;
  logic                    w_lt_u;
  logic                    w_lt;
  logic [1:0]              w_cmp_code;
  logic [WIDTH-1:0]        w_cmp_res;
  logic [SH_W-1:0]         w_sh;
  logic [SH_W:0]           w_rot_amt;
  logic signed [WIDTH-1:0] w_sra_s;
  logic [WIDTH-1:0]        w_shr;
  logic [WIDTH-1:0]        w_shl;
  logic [WIDTH-1:0]        w_sra;
  logic [WIDTH-1:0]        w_rot;
  logic [WIDTH-1:0]        w_res;
  logic [WIDTH-1:0]        w_hi;
  logic                    w_carry;
  logic                    w_err;

  // Divider step wires
  logic [WIDTH:0]   w_rem_sh;
  logic             w_rem_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  assign w_unit = bus.ALU_FUN[3:2];
  assign w_op   = bus.ALU_FUN[1:0];

  // A new op may enter only when idle and the output slot is free or being
  // drained on this same edge.
  assign w_in_ready  = !RST && (r_state == ST_IDLE) && (!r_out_valid || bus.Out_Ready);
  assign w_accept    = bus.In_Valid && w_in_ready;
  // Divide-by-zero completes in a single cycle, so only B!=0 starts iterating.
  assign w_div_start = w_accept && (bus.ALU_FUN == 4'b0011) && (bus.B != '0);
  assign w_div_last  = (r_state == ST_DIV) && (r_div_cnt == CNT_LAST);

  // Arithmetic
  assign w_sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_diff = bus.A - bus.B;
  assign w_prod = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};

  // Compare: code 1 equal, 2 greater, 3 less
  assign w_eq       = (bus.A == bus.B);
  assign w_lt_s     = ($signed(bus.A) < $signed(bus.B));
  assign w_lt_u     = (bus.A < bus.B);
  assign w_lt       = SIGNED_CMP ? w_lt_s : w_lt_u;
  assign w_cmp_code = w_eq ? 2'd1 : (w_lt ? 2'd3 : 2'd2);
  assign w_cmp_res  = {{(WIDTH-2){1'b0}}, w_cmp_code};

  // Shifts use only the low log2(WIDTH) bits of B
  assign w_sh      = bus.B[SH_W-1:0];
  assign w_shr     = bus.A >> w_sh;
  assign w_shl     = bus.A << w_sh;
  assign w_sra_s   = $signed(bus.A) >>> w_sh;
  assign w_sra     = SIGNED_CMP ? w_sra_s : w_shr;
  // With w_sh==0 the right-hand term shifts by WIDTH and contributes zero.
  assign w_rot_amt = W_LIT - {1'b0, w_sh};
  assign w_rot     = w_shl | (bus.A >> w_rot_amt);

  // Restoring divide step: shift in next dividend bit, subtract if it fits.
  assign w_rem_sh  = {r_div_rem, r_div_q[WIDTH-1]};
  assign w_rem_ge  = (w_rem_sh >= {1'b0, r_div_b});
  assign w_rem_nxt = w_rem_ge ? (w_rem_sh[WIDTH-1:0] - r_div_b) : w_rem_sh[WIDTH-1:0];
  assign w_q_nxt   = {r_div_q[WIDTH-2:0], w_rem_ge};

  // Single-cycle result selection (DIV entry here covers only B==0)
  always_comb begin
    w_res   = '0;
    w_hi    = '0;
    w_carry = 1'b0;
    w_err   = 1'b0;
    case (w_unit)
      2'b00: begin
        case (w_op)
          2'b00: begin
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
          end
          2'b01: begin
            w_res   = w_diff;
            w_carry = w_lt_u;
          end
          2'b10: begin
            w_res = w_prod[WIDTH-1:0];
            w_hi  = w_prod[2*WIDTH-1:WIDTH];
          end
          2'b11: begin
            w_res = '1;
            w_hi  = bus.A;
            w_err = 1'b1;
          end
          default: w_res = '0;
        endcase
      end
      2'b01: begin
        case (w_op)
          2'b00:   w_res = bus.A & bus.B;
          2'b01:   w_res = bus.A | bus.B;
          2'b10:   w_res = ~(bus.A & bus.B);
          2'b11:   w_res = ~(bus.A | bus.B);
          default: w_res = '0;
        endcase
      end
      2'b10: begin
        if (w_op == 2'b00) begin
          w_res = '0;
        end else begin
          w_res = w_cmp_res;
        end
      end
      2'b11: begin
        case (w_op)
          2'b00:   w_res = w_shr;
          2'b01:   w_res = w_shl;
          2'b10:   w_res = w_sra;
          2'b11:   w_res = w_rot;
          default: w_res = '0;
        endcase
      end
      default: w_res = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_div_start) begin
          w_state_nxt = ST_DIV;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (w_div_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DIV;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Divider operand capture and iteration
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_div_q   <= '0;
      r_div_rem <= '0;
      r_div_b   <= '0;
      r_div_cnt <= '0;
    end else if (w_div_start) begin
      r_div_q   <= bus.A;
      r_div_rem <= '0;
      r_div_b   <= bus.B;
      r_div_cnt <= '0;
    end else if (r_state == ST_DIV) begin
      r_div_q   <= w_q_nxt;
      r_div_rem <= w_rem_nxt;
      r_div_cnt <= r_div_cnt + CNT_W'(1);
    end
  end

  // Output stage: load on divider completion or single-cycle accept, else drain
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
      r_unit_sel  <= 2'b00;
      r_out_valid <= 1'b0;
    end else if (w_div_last) begin
      r_result    <= w_q_nxt;
      r_result_hi <= w_rem_nxt;
      r_carry     <= 1'b0;
      r_zero      <= (w_q_nxt == '0);
      r_err       <= 1'b0;
      r_unit_sel  <= 2'b00;
      r_out_valid <= 1'b1;
    end else if (w_accept && !w_div_start) begin
      r_result    <= w_res;
      r_result_hi <= w_hi;
      r_carry     <= w_carry;
      r_zero      <= (w_res == '0);
      r_err       <= w_err;
      r_unit_sel  <= w_unit;
      r_out_valid <= 1'b1;
    end else if (bus.Out_Ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.In_Ready  = w_in_ready;
  assign bus.Out_Valid = r_out_valid;
  assign bus.Result    = r_result;
  assign bus.Result_Hi = r_result_hi;
  assign bus.Carry_OUT = r_carry;
  assign bus.Zero_Flag = r_zero;
  assign bus.Err_Flag  = r_err;
  assign bus.Unit_Sel  = r_unit_sel;
  assign bus.Busy      = (r_state == ST_DIV);

endmodule

// File: tb/tb_alu_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_unit
// Self-checking bench for alu_seq_unit (WIDTH=16, SIGNED_CMP=1): directed
// vector table, randomized ops against an arithmetic reference model, and
// hand-written sequences for reset, throughput, backpressure and division.
// ---------------------------------------------------------------------------
module tb_alu_seq_unit;

  localparam int W = 16;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  alu_seq_unit_if #(.WIDTH(W)) bus ();

  alu_seq_unit #(.WIDTH(W), .SIGNED_CMP(1'b1)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic        c;
    logic        z;
    logic        e;
    logic [1:0]  u;
  } exp_t;

  typedef struct {
    logic [3:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] hi;
    logic        c;
    logic        z;
    logic        e;
    int          lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endfunction

  // Reference model computed from the operation definitions with integer math
  function automatic exp_t model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint ua, ub, sa, sb, s, d, q;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[15] ? ua - 65536 : ua;
    sb = b[15] ? ub - 65536 : ub;
    s  = longint'(b[3:0]);
    d  = longint'(1) << s;
    e.res = 16'h0; e.hi = 16'h0; e.c = 1'b0; e.e = 1'b0; e.u = f[3:2];
    case (f)
      4'h0: begin e.res = 16'((ua + ub) % 65536); e.c = ((ua + ub) > 65535); end
      4'h1: begin e.res = 16'((ua - ub + 65536) % 65536); e.c = (ua < ub); end
      4'h2: begin e.res = 16'((ua * ub) % 65536); e.hi = 16'((ua * ub) / 65536); end
      4'h3: begin
        if (ub == 0) begin e.res = 16'hFFFF; e.hi = a; e.e = 1'b1; end
        else begin e.res = 16'(ua / ub); e.hi = 16'(ua % ub); end
      end
      4'h4: e.res = a & b;
      4'h5: e.res = a | b;
      4'h6: e.res = ~(a & b);
      4'h7: e.res = ~(a | b);
      4'h8: e.res = 16'h0;
      4'h9, 4'hA, 4'hB: e.res = (sa == sb) ? 16'd1 : ((sa > sb) ? 16'd2 : 16'd3);
      4'hC: e.res = 16'(ua / d);
      4'hD: e.res = 16'((ua * d) % 65536);
      4'hE: begin
        q = sa / d;
        if (sa < 0 && (sa % d) != 0) q = q - 1;
        e.res = 16'(q);
      end
      4'hF: e.res = 16'((ua * d + ua / (longint'(65536) / d)) % 65536);
      default: e.res = 16'h0;
    endcase
    e.z = (e.res == 16'h0);
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    check({tag, "_res"},  bus.Result,    e.res);
    check({tag, "_hi"},   bus.Result_Hi, e.hi);
    check({tag, "_cy"},   bus.Carry_OUT, e.c);
    check({tag, "_zero"}, bus.Zero_Flag, e.z);
    check({tag, "_err"},  bus.Err_Flag,  e.e);
    check({tag, "_unit"}, bus.Unit_Sel,  e.u);
  endtask

  // Issue one op starting at a negedge; returns at the negedge where Out_Valid is seen.
  // lat counts negedges after the acceptance edge (1 = next cycle).
  task automatic exec_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b, output int lat);
    int n;
    bus.In_Valid = 1'b1;
    bus.ALU_FUN  = f;
    bus.A        = a;
    bus.B        = b;
    #1;
    n = 0;
    while (!bus.In_Ready && n < 200) begin
      @(negedge CLK); #1; n++;
    end
    if (n >= 200) begin
      n_fail++;
      $display("FAIL accept_timeout: got no In_Ready required In_Ready=1 within 200 cycles");
    end
    @(posedge CLK);
    @(negedge CLK);
    bus.In_Valid = 1'b0;
    lat = 1;
    while (!bus.Out_Valid && lat < 200) begin
      @(negedge CLK); lat++;
    end
    if (lat >= 200) begin
      n_fail++;
      $display("FAIL result_timeout: got no Out_Valid required Out_Valid=1 within 200 cycles");
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vt [15];
    exp_t  e;
    int    lat;
    int    bad;
    logic [3:0]  rf;
    logic [15:0] ra, rb;

    // f, a, b, res, hi, carry, zero, err, latency
    vt[0]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1};
    vt[1]  = '{4'h2, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 1'b0, 1'b0, 1};
    vt[2]  = '{4'h1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    vt[3]  = '{4'h3, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b1, 1};
    vt[4]  = '{4'h3, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 1'b0, W + 1};
    vt[5]  = '{4'hE, 16'h8000, 16'h0003, 16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vt[6]  = '{4'hF, 16'h8001, 16'h0014, 16'h0018, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vt[7]  = '{4'h9, 16'hFFFF, 16'h0001, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vt[8]  = '{4'h8, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
    vt[9]  = '{4'hA, 16'h0007, 16'h0007, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vt[10] = '{4'h4, 16'h0F0F, 16'h00FF, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vt[11] = '{4'h7, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vt[12] = '{4'h6, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
    vt[13] = '{4'hD, 16'h0001, 16'h00FF, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vt[14] = '{4'hB, 16'h0002, 16'hFFFE, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 1};

    RST = 1'b1;
    bus.In_Valid  = 1'b0;
    bus.Out_Ready = 1'b1;
    bus.A = 16'h0; bus.B = 16'h0; bus.ALU_FUN = 4'h0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_out_valid", bus.Out_Valid, 1'b0);
    check("rst_result",    bus.Result,    16'h0);
    check("rst_hi",        bus.Result_Hi, 16'h0);
    check("rst_flags",     {bus.Carry_OUT, bus.Zero_Flag, bus.Err_Flag, bus.Busy}, 4'b0000);
    check("rst_unit",      bus.Unit_Sel,  2'b00);
    check("rst_in_ready",  bus.In_Ready,  1'b0);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_in_ready", bus.In_Ready, 1'b1);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      exec_op(vt[i].f, vt[i].a, vt[i].b, lat);
      check($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      e.res = vt[i].res; e.hi = vt[i].hi; e.c = vt[i].c;
      e.z = vt[i].z; e.e = vt[i].e; e.u = vt[i].f[3:2];
      check_out($sformatf("vec%0d", i), e);
    end
    @(negedge CLK);

    // Divider: Busy high and In_Ready low for WIDTH cycles, then result
    bus.In_Valid = 1'b1; bus.ALU_FUN = 4'h3; bus.A = 16'd100; bus.B = 16'd7;
    #1;
    @(posedge CLK);
    @(negedge CLK);
    bus.In_Valid = 1'b0;
    bad = 0;
    for (int i = 0; i < W; i++) begin
      if (!(bus.Busy && !bus.In_Ready && !bus.Out_Valid)) bad++;
      @(negedge CLK);
    end
    check("div_busy_window_errors", bad, 0);
    check("div_done_valid", bus.Out_Valid, 1'b1);
    check("div_done_busy",  bus.Busy,      1'b0);
    check("div_done_q",     bus.Result,    16'd14);
    check("div_done_r",     bus.Result_Hi, 16'd2);
    @(negedge CLK);

    // Back-to-back throughput with Out_Ready held high
    for (int k = 0; k < 4; k++) begin
      bus.In_Valid = 1'b1; bus.ALU_FUN = 4'h0;
      bus.A = 16'(k * 3 + 1); bus.B = 16'h0010;
      #1;
      check($sformatf("b2b%0d_in_ready", k), bus.In_Ready, 1'b1);
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("b2b%0d_valid", k), bus.Out_Valid, 1'b1);
      check($sformatf("b2b%0d_res", k),   bus.Result,    16'(k * 3 + 1 + 16));
    end
    bus.In_Valid = 1'b0;
    @(negedge CLK);
    check("b2b_drain_valid", bus.Out_Valid, 1'b0);

    // Backpressure: held result, stalled second op, same-edge replace
    bus.Out_Ready = 1'b0;
    bus.In_Valid = 1'b1; bus.ALU_FUN = 4'h4; bus.A = 16'h0F0F; bus.B = 16'h00FF;
    #1;
    @(posedge CLK);
    @(negedge CLK);
    check("bp_and_valid", bus.Out_Valid, 1'b1);
    check("bp_and_res",   bus.Result,    16'h000F);
    check("bp_in_ready",  bus.In_Ready,  1'b0);
    bus.ALU_FUN = 4'h5;
    bad = 0;
    repeat (3) begin
      @(negedge CLK);
      if (!(bus.Out_Valid && bus.Result == 16'h000F && !bus.In_Ready)) bad++;
    end
    check("bp_hold_errors", bad, 0);
    bus.Out_Ready = 1'b1;
    #1;
    check("bp_release_in_ready", bus.In_Ready, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    bus.In_Valid = 1'b0;
    check("bp_or_valid", bus.Out_Valid, 1'b1);
    check("bp_or_res",   bus.Result,    16'h0FFF);
    check("bp_or_unit",  bus.Unit_Sel,  2'b01);
    @(negedge CLK);
    check("bp_no_dup", bus.Out_Valid, 1'b0);

    // Reset in the middle of a division aborts it
    bus.In_Valid = 1'b1; bus.ALU_FUN = 4'h3; bus.A = 16'd1000; bus.B = 16'd3;
    #1;
    @(posedge CLK);
    @(negedge CLK);
    bus.In_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_valid",  bus.Out_Valid, 1'b0);
    check("abort_busy",   bus.Busy,      1'b0);
    check("abort_result", {bus.Result, bus.Result_Hi}, 32'h0);
    check("abort_ready",  bus.In_Ready,  1'b0);
    RST = 1'b0;
    #1;
    check("abort_release_ready", bus.In_Ready, 1'b1);
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (bus.Out_Valid || bus.Busy) bad++;
    end
    check("abort_no_result", bad, 0);
    exec_op(4'h0, 16'd2, 16'd3, lat);
    check("abort_add_lat", lat, 1);
    check("abort_add_res", bus.Result, 16'd5);

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      rf = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 16'h0;
      if ($urandom_range(0, 5) == 0) ra = rb;
      exec_op(rf, ra, rb, lat);
      e = model(rf, ra, rb);
      check($sformatf("rnd%0d_lat", i), lat, (rf == 4'h3 && rb != 16'h0) ? W + 1 : 1);
      check_out($sformatf("rnd%0d_f%0h", i, rf), e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
